idex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-delivery stage of the pipelined RV32I core; it is the driving end of the ALU interface (operand A, operand B, 4-bit ALU control).
- Captures decoded instructions from ID and resolves EX/MEM and WB forwarding.
- Detects load-use hazards, inserting one bubble and stalling ID.
- Honours downstream freeze and branch flush.

---
 rtl/idex_operand_stage.sv | 165 ++++++++++++++++
 tb/tb_idex_operand_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and WB operand forwarding, load-use bubble
// insertion, downstream freeze and branch flush. Drives the ALU operand interface.
module idex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rs1_val,
    input  logic [XLEN-1:0]   id_rs2_val,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_a_pc,
    input  logic              id_b_imm,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [4:0]        exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [4:0]        wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_a_val,
    output logic [XLEN-1:0]   ex_b_val,
    output logic [3:0]        ex_alu_ctrl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [3:0] ALU_ADD = 4'b0000;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_rs1_val;
    logic [XLEN-1:0]   r_rs2_val;
    logic [XLEN-1:0]   r_imm;
    logic              r_a_pc;
    logic              r_b_imm;
    logic [3:0]        r_alu_ctrl;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;
    logic              w_load_use;
    logic              w_to_bubble;
    logic              w_capture;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // A load in EX/MEM has no data yet, so only non-load results are forwarded from there.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] captured,
        input logic [4:0]      em_rd,
        input logic            em_rw,
        input logic            em_mr,
        input logic [XLEN-1:0] em_res,
        input logic [4:0]      w_rd,
        input logic            w_rw,
        input logic [XLEN-1:0] w_dat
    );
        if (rs == 5'd0)
            return '0;
        else if (em_rw && !em_mr && em_rd == rs)
            return em_res;
        else if (w_rw && w_rd == rs)
            return w_dat;
        else
            return captured;
    endfunction

    always_comb begin
        w_fwd_rs1 = fwd_sel(r_rs1, r_rs1_val, exmem_rd, exmem_reg_write, exmem_mem_read,
                            exmem_result, wb_rd, wb_reg_write, wb_data);
        w_fwd_rs2 = fwd_sel(r_rs2, r_rs2_val, exmem_rd, exmem_reg_write, exmem_mem_read,
                            exmem_result, wb_rd, wb_reg_write, wb_data);
    end

    assign w_load_use  = r_valid && r_mem_read && (r_rd != 5'd0) && id_valid &&
                         ((id_rs1 == r_rd) || (id_rs2 == r_rd));
    assign w_to_bubble = flush || (!mem_stall && (w_load_use || !id_valid));
    assign w_capture   = !flush && !mem_stall && !w_load_use && id_valid;
    assign id_stall    = !rst && !flush && (mem_stall || w_load_use);

    // ID -> EX register boundary
    always_ff @(posedge clk) begin
        if (rst || w_to_bubble) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_a_pc      <= 1'b0;
            r_b_imm     <= 1'b0;
            r_alu_ctrl  <= ALU_ADD;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_pc        <= id_pc;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_rs1_val   <= id_rs1_val;
            r_rs2_val   <= id_rs2_val;
            r_imm       <= id_imm;
            r_a_pc      <= id_a_pc;
            r_b_imm     <= id_b_imm;
            r_alu_ctrl  <= id_alu_ctrl;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
        end else if (mem_stall) begin
            // Refresh operands while frozen so a value forwarded from WB outlives its retirement.
            r_rs1_val   <= w_fwd_rs1;
            r_rs2_val   <= w_fwd_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_bubble_cnt <= '0;
        else if (!flush && !mem_stall && w_load_use)
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end

    assign ex_valid      = r_valid;
    assign ex_a_val      = r_a_pc  ? r_pc  : w_fwd_rs1;
    assign ex_b_val      = r_b_imm ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign ex_alu_ctrl   = r_alu_ctrl;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage; the bubble counter is built narrow (8 bits)
// so that saturation is reached in a few hundred cycles.
module tb_idex_operand_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]   id_rs1_val, id_rs2_val, id_imm;
    logic              id_a_pc, id_b_imm;
    logic [3:0]        id_alu_ctrl;
    logic              id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]        exmem_rd;
    logic              exmem_reg_write, exmem_mem_read;
    logic [XLEN-1:0]   exmem_result;
    logic [4:0]        wb_rd;
    logic              wb_reg_write;
    logic [XLEN-1:0]   wb_data;
    logic              flush, mem_stall;
    logic              id_stall, ex_valid;
    logic [XLEN-1:0]   ex_a_val, ex_b_val, ex_store_data;
    logic [3:0]        ex_alu_ctrl;
    logic [4:0]        ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    idex_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_a_pc(id_a_pc), .id_b_imm(id_b_imm), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .flush(flush), .mem_stall(mem_stall),
        .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_a_val(ex_a_val), .ex_b_val(ex_b_val), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [3:0] alu, input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_val = v1; id_rs2_val = v2; id_alu_ctrl = alu;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
        id_a_pc = 1'b0; id_b_imm = 1'b0; id_imm = '0; id_pc = '0;
    endtask

    task automatic clear_fwd();
        exmem_rd = '0; exmem_reg_write = 1'b0; exmem_mem_read = 1'b0; exmem_result = '0;
        wb_rd = '0; wb_reg_write = 1'b0; wb_data = '0;
    endtask

    task automatic check_reset_state(input string p);
        check({p, "_valid"}, 32'(ex_valid), 32'd0);
        check({p, "_alu"},   32'(ex_alu_ctrl), 32'd0);
        check({p, "_a"},     ex_a_val, 32'd0);
        check({p, "_b"},     ex_b_val, 32'd0);
        check({p, "_st"},    ex_store_data, 32'd0);
        check({p, "_rd"},    32'(ex_rd), 32'd0);
        check({p, "_ctl"},   {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        check({p, "_cnt"},   32'(bubble_cnt), 32'd0);
        check({p, "_stall"}, 32'(id_stall), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        clear_fwd();
        tick(); tick();
        check_reset_state("rst0");
        rst = 1'b0;

        // Test 1: SUB x6,x5,x1 with x5 in EX/MEM (7) and WB (3)
        set_id(1'b1, 5'd5, 5'd1, 5'd6, 32'h99, 32'd2, 4'b1000, 1'b1, 1'b0);
        exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'd7;
        wb_rd = 5'd5; wb_reg_write = 1'b1; wb_data = 32'd3;
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        #1;
        check("t1_a_exmem", ex_a_val, 32'd7);
        check("t1_b", ex_b_val, 32'd2);
        check("t1_stall", 32'(id_stall), 32'd0);
        check("t1_valid", 32'(ex_valid), 32'd1);
        check("t1_alu", 32'(ex_alu_ctrl), 32'h8);
        check("t1_rd", 32'(ex_rd), 32'd6);
        exmem_reg_write = 1'b0; #1;
        check("t1_a_wb", ex_a_val, 32'd3);
        wb_reg_write = 1'b0; #1;
        check("t1_a_cap", ex_a_val, 32'h99);
        exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; #1;
        check("t1_a_noload", ex_a_val, 32'h99);
        clear_fwd();
        // Capture a bubble so the next test starts from a clean EX
        tick();

        // Test 3: x0 guard, plus PC/immediate operand select with a non-forwardable load
        set_id(1'b1, 5'd0, 5'd3, 5'd7, 32'h55, 32'h33, 4'd0, 1'b1, 1'b0);
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'hFFFF;
        wb_rd = 5'd0; wb_reg_write = 1'b1; wb_data = 32'h77;
        tick();
        check("t3_x0", ex_a_val, 32'd0);
        set_id(1'b1, 5'd0, 5'd3, 5'd7, 32'h0, 32'h33, 4'd0, 1'b1, 1'b0);
        id_a_pc = 1'b1; id_b_imm = 1'b1; id_pc = 32'h100; id_imm = 32'h2000;
        clear_fwd();
        tick();
        exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; exmem_result = 32'hDEAD;
        #1;
        check("t3_a_pc", ex_a_val, 32'h100);
        check("t3_b_imm", ex_b_val, 32'h2000);
        check("t3_store", ex_store_data, 32'h33);
        clear_fwd();

        // Test 2: LW x8 then ADD x9,x8,x8
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd8, 5'd9, 32'h11, 32'h11, 4'd0, 1'b1, 1'b0);
        #1;
        check("t2_stall_t", 32'(id_stall), 32'd1);
        tick();
        check("t2_bubble_valid", 32'(ex_valid), 32'd0);
        check("t2_bubble_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        check("t2_bubble_rd", 32'(ex_rd), 32'd0);
        check("t2_cnt", 32'(bubble_cnt), 32'd1);
        check("t2_stall_t1", 32'(id_stall), 32'd0);
        tick();
        wb_rd = 5'd8; wb_reg_write = 1'b1; wb_data = 32'h1234;
        #1;
        check("t2_valid_t2", 32'(ex_valid), 32'd1);
        check("t2_a_wb", ex_a_val, 32'h1234);
        check("t2_b_wb", ex_b_val, 32'h1234);
        clear_fwd();

        // Test 4: mem_stall hold while WB retires
        set_id(1'b1, 5'd4, 5'd0, 5'd10, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0);
        wb_rd = 5'd4; wb_reg_write = 1'b1; wb_data = 32'hAA;
        tick();
        check("t4_a_init", ex_a_val, 32'hAA);
        mem_stall = 1'b1;
        set_id(1'b1, 5'd1, 5'd2, 5'd11, 32'h5, 32'h6, 4'd3, 1'b1, 1'b0);
        #1;
        check("t4_stall_pre", 32'(id_stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) begin
                wb_reg_write = 1'b0; wb_data = 32'hBB;
            end
            #1;
            check("t4_a_hold", ex_a_val, 32'hAA);
            check("t4_rd_hold", 32'(ex_rd), 32'd10);
            check("t4_valid_hold", 32'(ex_valid), 32'd1);
            check("t4_stall", 32'(id_stall), 32'd1);
        end
        mem_stall = 1'b0;
        clear_fwd();

        // Test 5: flush beats both mem_stall and a load-use hazard
        set_id(1'b1, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd12, 5'd0, 5'd13, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
        flush = 1'b1; mem_stall = 1'b1;
        #1;
        check("t5_stall_flush", 32'(id_stall), 32'd0);
        tick();
        flush = 1'b0; mem_stall = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        #1;
        check("t5_valid", 32'(ex_valid), 32'd0);
        check("t5_mr", 32'(ex_mem_read), 32'd0);
        check("t5_cnt", 32'(bubble_cnt), 32'd1);
        check("t5_stall_after", 32'(id_stall), 32'd0);

        // Test 6: 2^CNT_W+5 load-use events on top of the one already counted
        for (int k = 1; k <= (1 << CNT_W) + 5; k++) begin
            set_id(1'b1, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd0, 5'd8, 5'd9, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
            tick();
            if (k == 200) check("t6_cnt_mid", 32'(bubble_cnt), 32'd201);
        end
        check("t6_cnt_sat", 32'(bubble_cnt), 32'hFF);

        // Reset asserted in the middle of a load-use stall
        set_id(1'b1, 5'd0, 5'd0, 5'd14, 32'd0, 32'd0, 4'b0111, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd14, 5'd0, 5'd15, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
        mem_stall = 1'b1;
        #1;
        check("t6_stall_pre", 32'(id_stall), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_stall_in_rst", 32'(id_stall), 32'd0);
        tick();
        rst = 1'b0; mem_stall = 1'b0;
        #1;
        check_reset_state("rst1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
